tlb_mp: RTL

Parametrised successor to the core's fixed 16-entry, 2-port combinational TLB. Entry count, search-port count and fill policy are configurable. Search results are registered with a valid handshake. The block owns the TLBFILL replacement index and reports multi-hit and illegal-INVTLB events. It sits beside `csr` in the core top: search ports serve IF, EX and any later page walker, and write, read and invalidate come from WB/EX.

---
 rtl/tlb_pkg.sv | 50 +++++
 rtl/tlb_search_port.sv | 103 ++++++++++
 rtl/tlb_mp.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/tlb_pkg.sv
// Shared TLB definitions: entry layout, page sizes, INVTLB opcodes and
// the ps-aware VA/ASID match used by both search and invalidation.
package tlb_pkg;

    localparam logic [5:0] PS_4K = 6'd12;
    localparam logic [5:0] PS_4M = 6'd21;

    localparam logic [4:0] INV_ALL0    = 5'd0;
    localparam logic [4:0] INV_ALL1    = 5'd1;
    localparam logic [4:0] INV_G1      = 5'd2;
    localparam logic [4:0] INV_G0      = 5'd3;
    localparam logic [4:0] INV_ASID    = 5'd4;
    localparam logic [4:0] INV_ASID_VA = 5'd5;
    localparam logic [4:0] INV_GA_VA   = 5'd6;

    typedef struct packed {
        logic        e;
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [19:0] ppn1;
        logic [1:0]  plv0;
        logic [1:0]  plv1;
        logic [1:0]  mat0;
        logic [1:0]  mat1;
        logic        d0;
        logic        d1;
        logic        v0;
        logic        v1;
    } tlb_entry_t;

    // A 4M page ignores the low 9 VPPN bits; anything else compares the full VPPN.
    function automatic logic tlb_va_match(input tlb_entry_t ent, input logic [18:0] vppn);
        logic m;
        if (ent.ps == PS_4M) begin
            m = (ent.vppn[18:9] == vppn[18:9]);
        end else begin
            m = (ent.vppn == vppn);
        end
        return m;
    endfunction

    function automatic logic tlb_match(input tlb_entry_t ent, input logic [18:0] vppn,
                                       input logic [9:0] asid);
        return ent.e && (ent.g || (ent.asid == asid)) && tlb_va_match(ent, vppn);
    endfunction

endpackage

// File: rtl/tlb_search_port.sv
// One TLB search port: match vector, lowest-index priority select,
// half-page mux and a registered result with a one-cycle valid pulse.
module tlb_search_port
    import tlb_pkg::*;
#(
    parameter int TLBNUM = 16,
    parameter int IDXW   = $clog2(TLBNUM)
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  tlb_entry_t [TLBNUM-1:0]       tlb,
    input  logic                          req,
    input  logic [18:0]                   vppn,
    input  logic                          va_bit12,
    input  logic [9:0]                    asid,
    output logic                          rvalid,
    output logic                          found,
    output logic [IDXW-1:0]               index,
    output logic [19:0]                   ppn,
    output logic [5:0]                    ps,
    output logic [1:0]                    plv,
    output logic [1:0]                    mat,
    output logic                          d,
    output logic                          v,
    output logic                          multi
);

    logic [TLBNUM-1:0] match_s;
    logic [IDXW-1:0]   hit_idx_s;
    logic              hit_s;
    logic              multi_s;
    logic              odd_s;
    tlb_entry_t        hit_ent_s;
    logic [19:0]       ppn_s;
    logic [5:0]        ps_s;
    logic [1:0]        plv_s;
    logic [1:0]        mat_s;
    logic              d_s;
    logic              v_s;

    // Match every entry, keep the lowest matching index, pick the half page.
    always_comb begin
        match_s   = '0;
        hit_idx_s = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            match_s[i] = tlb_match(tlb[i], vppn, asid);
            hit_idx_s  = match_s[i] ? IDXW'(i) : hit_idx_s;
        end
        hit_s     = |match_s;
        multi_s   = |(match_s & (match_s - TLBNUM'(1)));
        hit_ent_s = tlb[hit_idx_s];
        if (hit_ent_s.ps == PS_4M) begin
            odd_s = vppn[8];
        end else begin
            odd_s = va_bit12;
        end
        if (hit_s) begin
            ppn_s = odd_s ? hit_ent_s.ppn1 : hit_ent_s.ppn0;
            plv_s = odd_s ? hit_ent_s.plv1 : hit_ent_s.plv0;
            mat_s = odd_s ? hit_ent_s.mat1 : hit_ent_s.mat0;
            d_s   = odd_s ? hit_ent_s.d1   : hit_ent_s.d0;
            v_s   = odd_s ? hit_ent_s.v1   : hit_ent_s.v0;
            ps_s  = hit_ent_s.ps;
        end else begin
            ppn_s = 20'd0;
            plv_s = 2'd0;
            mat_s = 2'd0;
            d_s   = 1'b0;
            v_s   = 1'b0;
            ps_s  = 6'd0;
        end
    end

    // Capture the result on a request; hold it until the next request.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rvalid <= 1'b0;
            found  <= 1'b0;
            index  <= '0;
            ppn    <= 20'd0;
            ps     <= 6'd0;
            plv    <= 2'd0;
            mat    <= 2'd0;
            d      <= 1'b0;
            v      <= 1'b0;
            multi  <= 1'b0;
        end else if (req) begin
            rvalid <= 1'b1;
            found  <= hit_s;
            index  <= hit_idx_s;
            ppn    <= ppn_s;
            ps     <= ps_s;
            plv    <= plv_s;
            mat    <= mat_s;
            d      <= d_s;
            v      <= v_s;
            multi  <= multi_s;
        end else begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/tlb_mp.sv
// Parametrised multi-port TLB: entry table, TLBFILL index generator,
// INVTLB invalidation and NSRCH registered search ports.
module tlb_mp
    import tlb_pkg::*;
#(
    parameter int  TLBNUM    = 16,
    parameter int  NSRCH     = 2,
    parameter int  FILL_MODE = 0,
    localparam int IDXW      = $clog2(TLBNUM)
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [NSRCH-1:0]        s_req,
    input  logic [19*NSRCH-1:0]     s_vppn,
    input  logic [NSRCH-1:0]        s_va_bit12,
    input  logic [10*NSRCH-1:0]     s_asid,
    output logic [NSRCH-1:0]        s_rvalid,
    output logic [NSRCH-1:0]        s_found,
    output logic [IDXW*NSRCH-1:0]   s_index,
    output logic [20*NSRCH-1:0]     s_ppn,
    output logic [6*NSRCH-1:0]      s_ps,
    output logic [2*NSRCH-1:0]      s_plv,
    output logic [2*NSRCH-1:0]      s_mat,
    output logic [NSRCH-1:0]        s_d,
    output logic [NSRCH-1:0]        s_v,
    output logic [NSRCH-1:0]        s_multi,
    input  logic                    we,
    input  logic                    fill,
    input  logic [IDXW-1:0]         w_index,
    input  logic                    w_e,
    input  logic [18:0]             w_vppn,
    input  logic [5:0]              w_ps,
    input  logic [9:0]              w_asid,
    input  logic                    w_g,
    input  logic [19:0]             w_ppn0,
    input  logic [19:0]             w_ppn1,
    input  logic [1:0]              w_plv0,
    input  logic [1:0]              w_plv1,
    input  logic [1:0]              w_mat0,
    input  logic [1:0]              w_mat1,
    input  logic                    w_d0,
    input  logic                    w_d1,
    input  logic                    w_v0,
    input  logic                    w_v1,
    output logic [IDXW-1:0]         fill_index,
    input  logic [IDXW-1:0]         r_index,
    output logic                    r_e,
    output logic [18:0]             r_vppn,
    output logic [5:0]              r_ps,
    output logic [9:0]              r_asid,
    output logic                    r_g,
    output logic [19:0]             r_ppn0,
    output logic [19:0]             r_ppn1,
    output logic [1:0]              r_plv0,
    output logic [1:0]              r_plv1,
    output logic [1:0]              r_mat0,
    output logic [1:0]              r_mat1,
    output logic                    r_d0,
    output logic                    r_d1,
    output logic                    r_v0,
    output logic                    r_v1,
    input  logic                    inv_valid,
    input  logic [4:0]              inv_op,
    input  logic [9:0]              inv_asid,
    input  logic [18:0]             inv_vppn,
    output logic                    inv_ill
);

    tlb_entry_t [TLBNUM-1:0] tlb_r;
    tlb_entry_t              w_ent_s;
    logic [TLBNUM-1:0]       inv_hit_s;
    logic                    inv_ill_s;
    logic [IDXW-1:0]         wr_idx_s;
    logic [7:0]              lfsr_r;
    logic [7:0]              lfsr_nxt_s;

    assign w_ent_s = '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                       ppn0: w_ppn0, ppn1: w_ppn1, plv0: w_plv0, plv1: w_plv1,
                       mat0: w_mat0, mat1: w_mat1, d0: w_d0, d1: w_d1, v0: w_v0, v1: w_v1};
    assign wr_idx_s   = fill ? fill_index : w_index;
    assign lfsr_nxt_s = {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};

    // Decode the INVTLB opcode into a per-entry kill vector.
    always_comb begin
        inv_hit_s = '0;
        inv_ill_s = 1'b0;
        for (int i = 0; i < TLBNUM; i++) begin
            case (inv_op)
                INV_ALL0, INV_ALL1: inv_hit_s[i] = 1'b1;
                INV_G1:      inv_hit_s[i] = tlb_r[i].g;
                INV_G0:      inv_hit_s[i] = !tlb_r[i].g;
                INV_ASID:    inv_hit_s[i] = !tlb_r[i].g && (tlb_r[i].asid == inv_asid);
                INV_ASID_VA: inv_hit_s[i] = !tlb_r[i].g && (tlb_r[i].asid == inv_asid)
                                            && tlb_va_match(tlb_r[i], inv_vppn);
                INV_GA_VA:   inv_hit_s[i] = (tlb_r[i].g || (tlb_r[i].asid == inv_asid))
                                            && tlb_va_match(tlb_r[i], inv_vppn);
                default:     inv_hit_s[i] = 1'b0;
            endcase
        end
        inv_ill_s = (inv_op > INV_GA_VA);
    end

    // Entry table: the write wins over a coincident invalidation of the same entry.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tlb_r <= '0;
        end else begin
            for (int i = 0; i < TLBNUM; i++) begin
                if (we && (wr_idx_s == IDXW'(i))) begin
                    tlb_r[i] <= w_ent_s;
                end else if (inv_valid && inv_hit_s[i]) begin
                    tlb_r[i].e <= 1'b0;
                end else begin
                    tlb_r[i] <= tlb_r[i];
                end
            end
        end
    end

    // Fill index advances only on fill writes, by counter or LFSR.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fill_index <= '0;
            lfsr_r     <= 8'h01;
        end else if (we && fill) begin
            if (FILL_MODE == 1) begin
                lfsr_r     <= lfsr_nxt_s;
                fill_index <= lfsr_nxt_s[IDXW-1:0];
            end else begin
                lfsr_r     <= lfsr_r;
                fill_index <= fill_index + IDXW'(1);
            end
        end else begin
            lfsr_r     <= lfsr_r;
            fill_index <= fill_index;
        end
    end

    // One-cycle pulse for an unsupported INVTLB opcode.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inv_ill <= 1'b0;
        end else begin
            inv_ill <= inv_valid && inv_ill_s;
        end
    end

    assign r_e    = tlb_r[r_index].e;
    assign r_vppn = tlb_r[r_index].vppn;
    assign r_ps   = tlb_r[r_index].ps;
    assign r_asid = tlb_r[r_index].asid;
    assign r_g    = tlb_r[r_index].g;
    assign r_ppn0 = tlb_r[r_index].ppn0;
    assign r_ppn1 = tlb_r[r_index].ppn1;
    assign r_plv0 = tlb_r[r_index].plv0;
    assign r_plv1 = tlb_r[r_index].plv1;
    assign r_mat0 = tlb_r[r_index].mat0;
    assign r_mat1 = tlb_r[r_index].mat1;
    assign r_d0   = tlb_r[r_index].d0;
    assign r_d1   = tlb_r[r_index].d1;
    assign r_v0   = tlb_r[r_index].v0;
    assign r_v1   = tlb_r[r_index].v1;

    for (genvar k = 0; k < NSRCH; k++) begin : g_srch
        tlb_search_port #(.TLBNUM(TLBNUM), .IDXW(IDXW)) u_port (
            .clk      (clk),
            .resetn   (resetn),
            .tlb      (tlb_r),
            .req      (s_req[k]),
            .vppn     (s_vppn[k*19 +: 19]),
            .va_bit12 (s_va_bit12[k]),
            .asid     (s_asid[k*10 +: 10]),
            .rvalid   (s_rvalid[k]),
            .found    (s_found[k]),
            .index    (s_index[k*IDXW +: IDXW]),
            .ppn      (s_ppn[k*20 +: 20]),
            .ps       (s_ps[k*6 +: 6]),
            .plv      (s_plv[k*2 +: 2]),
            .mat      (s_mat[k*2 +: 2]),
            .d        (s_d[k]),
            .v        (s_v[k]),
            .multi    (s_multi[k])
        );
    end

endmodule
